// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with PC, {pc, inst} FIFO, redirect handling and fault flags.
// Decode sees only registered/FIFO-storage values; the imem address is the only combinational output.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          IMEM_WORDS = 2048
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic [31:0]                   o_imem_addr,
  input  logic [31:0]                   i_imem_data,
  input  logic                          i_redirect_valid,
  input  logic [31:0]                   i_redirect_pc,
  output logic                          o_inst_valid,
  output logic [31:0]                   o_inst,
  output logic [31:0]                   o_inst_pc,
  input  logic                          i_inst_ready,
  output logic                          o_misalign_err,
  output logic                          o_range_err,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] LIMIT = 32'(IMEM_WORDS * 4);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic RUN = 1'b0;
  localparam logic HALT = 1'b1;
  logic          state;
  logic [31:0]   fetch_pc;
  logic [31:0]   mem_inst [FIFO_DEPTH];
  logic [31:0]   mem_pc   [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          in_range, tgt_ok, pop, push;
  assign in_range       = fetch_pc < LIMIT;
  assign tgt_ok         = i_redirect_pc < LIMIT;
  assign o_imem_addr    = fetch_pc;
  assign o_fifo_count   = count;
  assign o_inst_valid   = count != '0;
  assign o_inst         = o_inst_valid ? mem_inst[rd_ptr] : NOP;
  assign o_inst_pc      = o_inst_valid ? mem_pc[rd_ptr] : 32'h0;
  assign pop            = o_inst_valid & i_inst_ready & ~i_redirect_valid;
  // A full FIFO may still accept a push when the head leaves the same cycle.
  assign push           = (state == RUN) & ~i_redirect_valid & in_range & ((count != FULL) | pop);
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= i_imem_data;
      mem_pc[wr_ptr]   <= fetch_pc;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      fetch_pc       <= RESET_PC;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      o_misalign_err <= 1'b0;
      o_range_err    <= 1'b0;
    end else if (i_redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      if (i_redirect_pc[1:0] != 2'b00) begin
        fetch_pc       <= {i_redirect_pc[31:2], 2'b00};
        o_misalign_err <= 1'b1;
        state          <= HALT;
      end else if (!tgt_ok) begin
        fetch_pc    <= i_redirect_pc;
        o_range_err <= 1'b1;
        state       <= HALT;
      end else begin
        fetch_pc       <= i_redirect_pc;
        o_misalign_err <= 1'b0;
        o_range_err    <= 1'b0;
        state          <= RUN;
      end
    end else begin
      if (state == RUN && !in_range) begin
        o_range_err <= 1'b1;
        state       <= HALT;
      end
      if (push) begin
        wr_ptr   <= wr_ptr + PW'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the instruction memory and downstream into decode.
- Owns the fetch PC and drives the word address to the instruction memory; that memory returns data combinationally in the same cycle.
- Buffers fetched {pc, instruction} pairs in a small FIFO and presents them to decode with a valid/ready handshake.
- Handles control-flow redirects (branch/jump/trap), FIFO flush, and alignment and range faults.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded at reset.
- FIFO_DEPTH, 4, number of buffered entries; power of two, minimum 2.
- IMEM_WORDS, 2048, instruction memory size in 32-bit words; legal byte range is [0, IMEM_WORDS*4).

Ports:
- clk  input  1  clock, all state on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- o_imem_addr  output  32  byte address to instruction memory; equals fetch_pc, combinational from the register.
- i_imem_data  input  32  instruction word at o_imem_addr, valid in the same cycle.
- i_redirect_valid  input  1  redirect request, one-cycle pulse or held.
- i_redirect_pc  input  32  redirect target byte address.
- o_inst_valid  output  1  FIFO head valid.
- o_inst  output  32  FIFO head instruction.
- o_inst_pc  output  32  FIFO head PC.
- i_inst_ready  input  1  decode accepts the head this cycle.
- o_misalign_err  output  1  sticky: redirect target had pc[1:0] != 0.
- o_range_err  output  1  sticky: fetch_pc reached or passed IMEM_WORDS*4.
- o_fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (asynchronous, while rst_n = 0):
  - fetch_pc = RESET_PC; FIFO empty, count 0; state RUN.
  - o_inst_valid = 0, o_inst = 32'h0000_0013 (NOP), o_inst_pc = 0, both error flags 0.
- Reset mid-operation discards all FIFO contents immediately.
- States: RUN, HALT.
  - RUN -> HALT on a misaligned redirect, or when fetch_pc >= IMEM_WORDS*4.
  - HALT -> RUN only on an aligned, in-range redirect.
  - No fetches occur in HALT.
- Pop = o_inst_valid & i_inst_ready.
- Push is evaluated in RUN with no redirect:
  - Push occurs when count < FIFO_DEPTH, or when count == FIFO_DEPTH and pop is 1 (simultaneous pop+push while full).
  - A push writes {fetch_pc, i_imem_data} at the tail; fetch_pc <= fetch_pc + 4 (32-bit wrap, no carry out).
- Latency: the word fetched at edge N is visible on o_inst at cycle N+1 if the FIFO was empty. The first instruction is valid one cycle after rst_n deasserts.
- Occupancy updates:
  - Push and pop together: count unchanged.
  - Push only: +1.
  - Pop only: -1.
- When full and not popping: no push, fetch_pc holds, o_imem_addr stable.
- When empty: o_inst_valid = 0, o_inst = 32'h0000_0013, o_inst_pc = 0; i_inst_ready is ignored.
- Redirect (i_redirect_valid = 1) has priority over push and pop:
  - FIFO flushed, count 0 next cycle; no push or pop that cycle.
  - If i_redirect_pc[1:0] == 0 and the target is in range: fetch_pc <= i_redirect_pc, state RUN, both error flags cleared.
  - If misaligned: fetch_pc <= {i_redirect_pc[31:2], 2'b00}, o_misalign_err <= 1, state HALT.
  - If aligned but out of range: fetch_pc <= i_redirect_pc, o_range_err <= 1, state HALT.
- Range check in RUN: if fetch_pc >= IMEM_WORDS*4, there is no push, o_range_err <= 1, and the state goes to HALT. Already-buffered entries still drain to decode.
- The range check compares the full 32-bit value; o_imem_addr is still driven in HALT, but the data is ignored.
- Redirect held high for multiple cycles: the FIFO stays empty and fetch_pc is reloaded every cycle.
- FIFO pointers wrap modulo FIFO_DEPTH; full/empty are derived from count, never from pointer equality alone.
- All outputs except o_imem_addr are driven directly from registers or FIFO storage; there is no combinational path from i_imem_data to o_inst.

Test Plan:
- Reset with imem word at 0x0 = 0x00500093, i_inst_ready = 1 -> o_inst_valid rises one cycle after rst_n deasserts with o_inst = 0x00500093 and o_inst_pc = 0x0; next o_inst_pc = 0x4, 0x8, 0xC on consecutive cycles.
- i_inst_ready = 0 for 10 cycles -> o_fifo_count = 4, o_imem_addr holds 0x10; raise ready -> entries popped in order (PCs 0x0..0xC), then 0x10 follows with no gap.
- Redirect to 0x40 while FIFO holds 3 entries -> next cycle o_inst_valid = 0 and count 0; the following cycle o_inst_pc = 0x40. The pre-redirect entries never appear.
- Redirect to 0x42 -> o_misalign_err = 1, fetch stops, o_imem_addr = 0x40, no valid output; then redirect to 0x80 -> error cleared and o_inst_pc = 0x80 appears.
- Run sequentially from 0x1FF8 with IMEM_WORDS = 2048 -> PCs 0x1FF8 and 0x1FFC are delivered, then o_range_err = 1 at fetch_pc = 0x2000 and nothing further is pushed.
- Assert rst_n = 0 asynchronously mid-stream with count = 3 -> o_inst_valid = 0, count = 0 and errors = 0 immediately, before the next clock edge; after release, fetch restarts at RESET_PC.
